// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multicycle control unit: FSM state encoding,
// primary/secondary opcode values, pc_src and result_sel selector codes.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'h0,
        StDecode = 4'h1,
        StExR    = 4'h2,
        StExI    = 4'h3,
        StExSh   = 4'h4,
        StWb     = 4'h5,
        StMemDec = 4'h6,
        StLd     = 4'h7,
        StLdWb   = 4'h8,
        StSt     = 4'h9,
        StBcond  = 4'hA,
        StJal    = 4'hB,
        StJalWb  = 4'hC,
        StJcond  = 4'hD,
        StTrap   = 4'hE
    } state_e;

    // Primary opcodes (IR[15:12])
    localparam logic [3:0] OpRType  = 4'h0;
    localparam logic [3:0] OpAndi   = 4'h1;
    localparam logic [3:0] OpOri    = 4'h2;
    localparam logic [3:0] OpXori   = 4'h3;
    localparam logic [3:0] OpMem    = 4'h4;
    localparam logic [3:0] OpAddi   = 4'h5;
    localparam logic [3:0] OpShift  = 4'h8;
    localparam logic [3:0] OpImm9   = 4'h9;
    localparam logic [3:0] OpCmpi   = 4'hB;
    localparam logic [3:0] OpBcond  = 4'hC;
    localparam logic [3:0] OpMovi   = 4'hD;
    localparam logic [3:0] OpShiftI = 4'hF;

    // Secondary opcodes (IR[7:4])
    localparam logic [3:0] Op2Ld       = 4'h0;
    localparam logic [3:0] Op2St       = 4'h4;
    localparam logic [3:0] Op2ShiftReg = 4'h4;
    localparam logic [3:0] Op2Jal      = 4'h8;
    localparam logic [3:0] Op2Cmp      = 4'hB;
    localparam logic [3:0] Op2Jcond    = 4'hC;

    // pc_src encodings
    localparam logic [1:0] PcSrcInc  = 2'd0;
    localparam logic [1:0] PcSrcImm  = 2'd1;
    localparam logic [1:0] PcSrcReg  = 2'd2;
    localparam logic [1:0] PcSrcTrap = 2'd3;

    // result_sel encodings
    localparam logic [1:0] ResShift = 2'd0;
    localparam logic [1:0] ResAlu   = 2'd1;
    localparam logic [1:0] ResMem   = 2'd2;
    localparam logic [1:0] ResLink  = 2'd3;

    // ALU op driven whenever no instruction is selecting one
    localparam logic [3:0] AluDefault = 4'h5;

endpackage

// File: rtl/cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval
// Combinational branch/jump condition evaluator.
//   cond_code_i  4  condition selector (IR[11:8])
//   psr_i        5  flags {b4,b3,b2,b1,b0}
//   cond_true_o  1  selected condition holds
// ----------------------------------------------------------------------------
module cond_eval (
    input  logic [3:0] cond_code_i,
    input  logic [4:0] psr_i,
    output logic       cond_true_o
);

    always_comb begin
        cond_true_o = 1'b0;
        unique case (cond_code_i)
            4'h0: cond_true_o =  psr_i[4];
            4'h1: cond_true_o = !psr_i[4];
            4'h2: cond_true_o =  psr_i[3];
            4'h3: cond_true_o = !psr_i[3];
            4'h4: cond_true_o =  psr_i[0];
            4'h5: cond_true_o = !psr_i[0];
            4'h6: cond_true_o =  psr_i[1];
            4'h7: cond_true_o = !psr_i[1];
            4'h8: cond_true_o =  psr_i[2];
            4'h9: cond_true_o = !psr_i[2];
            4'hA: cond_true_o = !psr_i[4] && !psr_i[0];
            4'hB: cond_true_o =  psr_i[4] ||  psr_i[0];
            4'hC: cond_true_o = !psr_i[1] && !psr_i[4];
            4'hD: cond_true_o =  psr_i[4] ||  psr_i[1];
            4'hE: cond_true_o = 1'b1;
            4'hF: cond_true_o = 1'b0;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Fetch/decode/execute/writeback sequencer for the 16-bit datapath, with a
// variable-latency memory handshake, encoded PC source, retired-instruction
// counter and optional illegal-opcode trap (enable with ILLEGAL_OP_TRAP_EN).
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   opcode1_i/opcode2_i     IR[15:12] / IR[7:4]
//   cond_code_i, shamt_in_i IR[11:8] / IR[3:0]
//   psr_i                   flags {b4..b0}
//   mem_ready_i             memory completes the current access
//   mem_req_o/mem_we_o/mem_addr_sel_o   memory request, store, address select
//   ir_en_o, pc_en_o, pc_src_o, trap_vec_o  IR load, PC write and source
//   imm_en_o, zero_ext_o, src_b_imm_o   immediate handling
//   alu_ctrl_o, shift_ctrl_o, shamt_out_o  functional-unit controls
//   result_sel_o, result_en_o, psr_en_o, reg_we_o  result/flag/reg writes
//   retire_o, retired_cnt_o, illegal_o  retire pulse, count, illegal pulse
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned         WIDTH     = 16,
    parameter int unsigned         CNT_WIDTH = 32,
    parameter logic [WIDTH-1:0]    TRAP_VEC  = 'h0010
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [3:0]           opcode1_i,
    input  logic [3:0]           opcode2_i,
    input  logic [3:0]           cond_code_i,
    input  logic [3:0]           shamt_in_i,
    input  logic [4:0]           psr_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 mem_addr_sel_o,
    output logic                 ir_en_o,
    output logic                 pc_en_o,
    output logic [1:0]           pc_src_o,
    output logic [WIDTH-1:0]     trap_vec_o,
    output logic                 imm_en_o,
    output logic                 zero_ext_o,
    output logic                 src_b_imm_o,
    output logic [3:0]           alu_ctrl_o,
    output logic [3:0]           shift_ctrl_o,
    output logic [3:0]           shamt_out_o,
    output logic [1:0]           result_sel_o,
    output logic                 result_en_o,
    output logic                 psr_en_o,
    output logic                 reg_we_o,
    output logic                 retire_o,
    output logic [CNT_WIDTH-1:0] retired_cnt_o,
    output logic                 illegal_o
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 cond_true;

    cond_eval u_cond_eval (
        .cond_code_i (cond_code_i),
        .psr_i       (psr_i),
        .cond_true_o (cond_true)
    );

    assign trap_vec_o    = TRAP_VEC;
    assign shamt_out_o   = shamt_in_i;
    assign retired_cnt_o = cnt_q;

    // Next state and Moore/Mealy outputs. While reset is high everything
    // stays at its default so an in-flight memory access is dropped.
    always_comb begin
        state_d        = state_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_en_o        = 1'b0;
        pc_en_o        = 1'b0;
        pc_src_o       = PcSrcInc;
        imm_en_o       = 1'b0;
        zero_ext_o     = 1'b0;
        src_b_imm_o    = 1'b0;
        alu_ctrl_o     = AluDefault;
        shift_ctrl_o   = 4'h0;
        result_sel_o   = ResAlu;
        result_en_o    = 1'b0;
        psr_en_o       = 1'b0;
        reg_we_o       = 1'b0;
        retire_o       = 1'b0;
        illegal_o      = 1'b0;

        if (reset_i) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_en_o = 1'b1;
                        pc_en_o = 1'b1;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    imm_en_o   = 1'b1;
                    zero_ext_o = (opcode1_i == OpAndi) || (opcode1_i == OpOri) ||
                                 (opcode1_i == OpXori) || (opcode1_i == OpMovi);
                    unique case (opcode1_i)
                        OpRType: state_d = StExR;
                        OpAndi, OpOri, OpXori, OpAddi, OpImm9, OpCmpi, OpMovi:
                            state_d = StExI;
                        OpShift, OpShiftI: state_d = StExSh;
                        OpBcond: state_d = StBcond;
                        OpMem:   state_d = StMemDec;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            state_d = StTrap;
`else
                            retire_o = 1'b1;
                            state_d  = StFetch;
`endif
                        end
                    endcase
                end
                StExR: begin
                    alu_ctrl_o  = opcode2_i;
                    psr_en_o    = 1'b1;
                    result_en_o = 1'b1;
                    state_d     = StWb;
                end
                StExI: begin
                    alu_ctrl_o  = opcode1_i;
                    src_b_imm_o = 1'b1;
                    psr_en_o    = 1'b1;
                    result_en_o = 1'b1;
                    state_d     = StWb;
                end
                StExSh: begin
                    // Immediate-form shift always uses the F shifter op
                    shift_ctrl_o = (opcode1_i == OpShiftI) ? 4'hF : opcode2_i;
                    src_b_imm_o  = (opcode1_i == OpShiftI) || (opcode2_i != Op2ShiftReg);
                    result_sel_o = ResShift;
                    result_en_o  = 1'b1;
                    state_d      = StWb;
                end
                StWb: begin
                    // Compares only update flags
                    reg_we_o = !((opcode1_i == OpCmpi) ||
                                 ((opcode1_i == OpRType) && (opcode2_i == Op2Cmp)));
                    retire_o = 1'b1;
                    state_d  = StFetch;
                end
                StMemDec: begin
                    unique case (opcode2_i)
                        Op2Ld:    state_d = StLd;
                        Op2St:    state_d = StSt;
                        Op2Jal:   state_d = StJal;
                        Op2Jcond: state_d = StJcond;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            state_d = StTrap;
`else
                            retire_o = 1'b1;
                            state_d  = StFetch;
`endif
                        end
                    endcase
                end
                StLd: begin
                    mem_req_o      = 1'b1;
                    mem_addr_sel_o = 1'b1;
                    if (mem_ready_i) state_d = StLdWb;
                end
                StLdWb: begin
                    result_sel_o = ResMem;
                    reg_we_o     = 1'b1;
                    retire_o     = 1'b1;
                    state_d      = StFetch;
                end
                StSt: begin
                    mem_req_o      = 1'b1;
                    mem_we_o       = 1'b1;
                    mem_addr_sel_o = 1'b1;
                    if (mem_ready_i) begin
                        retire_o = 1'b1;
                        state_d  = StFetch;
                    end
                end
                StBcond: begin
                    pc_en_o  = cond_true;
                    pc_src_o = PcSrcImm;
                    retire_o = 1'b1;
                    state_d  = StFetch;
                end
                StJal: begin
                    result_sel_o = ResLink;
                    result_en_o  = 1'b1;
                    pc_en_o      = 1'b1;
                    pc_src_o     = PcSrcReg;
                    state_d      = StJalWb;
                end
                StJalWb: begin
                    reg_we_o = 1'b1;
                    retire_o = 1'b1;
                    state_d  = StFetch;
                end
                StJcond: begin
                    pc_en_o  = cond_true;
                    pc_src_o = PcSrcReg;
                    retire_o = 1'b1;
                    state_d  = StFetch;
                end
                StTrap: begin
                    illegal_o = 1'b1;
                    pc_en_o   = 1'b1;
                    pc_src_o  = PcSrcTrap;
                    state_d   = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    // Counter wraps naturally at 2^CNT_WIDTH
    always_comb begin
        cnt_d = cnt_q;
        if (retire_o) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode1, opcode2, cond_code, shamt_in;
    logic [4:0]  psr;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_en, pc_en;
    logic [1:0]  pc_src;
    logic [15:0] trap_vec;
    logic        imm_en, zero_ext, src_b_imm;
    logic [3:0]  alu_ctrl, shift_ctrl, shamt_out;
    logic [1:0]  result_sel;
    logic        result_en, psr_en, reg_we, retire, illegal;
    logic [31:0] retired_cnt;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .WIDTH     (16),
        .CNT_WIDTH (32),
        .TRAP_VEC  (16'h0010)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .opcode1_i      (opcode1),
        .opcode2_i      (opcode2),
        .cond_code_i    (cond_code),
        .shamt_in_i     (shamt_in),
        .psr_i          (psr),
        .mem_ready_i    (mem_ready),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_sel_o (mem_addr_sel),
        .ir_en_o        (ir_en),
        .pc_en_o        (pc_en),
        .pc_src_o       (pc_src),
        .trap_vec_o     (trap_vec),
        .imm_en_o       (imm_en),
        .zero_ext_o     (zero_ext),
        .src_b_imm_o    (src_b_imm),
        .alu_ctrl_o     (alu_ctrl),
        .shift_ctrl_o   (shift_ctrl),
        .shamt_out_o    (shamt_out),
        .result_sel_o   (result_sel),
        .result_en_o    (result_en),
        .psr_en_o       (psr_en),
        .reg_we_o       (reg_we),
        .retire_o       (retire),
        .retired_cnt_o  (retired_cnt),
        .illegal_o      (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs changed at the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the falling edge of a FETCH cycle; returns at the falling
    // edge of the first post-decode state.
    task automatic start_instr(input logic [3:0] op1, input logic [3:0] op2,
                               input logic [3:0] cc, input logic zext);
        opcode1   = op1;
        opcode2   = op2;
        cond_code = cc;
        mem_ready = 1'b1;
        #1;
        check("fetch mem_req", mem_req, 1);
        check("fetch addr_sel", mem_addr_sel, 0);
        check("fetch ir_en", ir_en, 1);
        check("fetch pc_en", pc_en, 1);
        check("fetch pc_src", pc_src, 0);
        check("fetch cnt", retired_cnt, exp_cnt);
        tick();
        check("decode imm_en", imm_en, 1);
        check("decode zero_ext", zero_ext, zext);
        check("decode mem_req", mem_req, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        opcode1 = '0; opcode2 = '0; cond_code = '0; shamt_in = 4'h7; psr = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst mem_req", mem_req, 0);
        check("rst alu_ctrl", alu_ctrl, 4'h5);
        check("rst result_sel", result_sel, 1);
        check("rst pc_en", pc_en, 0);
        check("rst retire", retire, 0);
        check("rst cnt", retired_cnt, 0);
        check("trap_vec", trap_vec, 16'h0010);
        check("shamt_out", shamt_out, 4'h7);
        reset = 1'b0;

        // ADDI: FETCH, DECODE, EX_I, WB
        start_instr(4'h5, 4'h0, 4'h0, 1'b0);
        check("addi alu", alu_ctrl, 4'h5);
        check("addi src_b_imm", src_b_imm, 1);
        check("addi psr_en", psr_en, 1);
        check("addi reg_we ex", reg_we, 0);
        tick();
        check("addi reg_we wb", reg_we, 1);
        check("addi retire", retire, 1);
        check("addi cnt wb", retired_cnt, 0);
        tick(); exp_cnt++;

        // ANDI: zero-extended immediate
        start_instr(4'h1, 4'h0, 4'h0, 1'b1);
        check("andi alu", alu_ctrl, 4'h1);
        tick();
        check("andi retire", retire, 1);
        tick(); exp_cnt++;

        // LD with mem_ready low three cycles
        start_instr(4'h4, 4'h0, 4'h0, 1'b0);
        check("memdec mem_req", mem_req, 0);
        check("memdec retire", retire, 0);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("ld mem_req", mem_req, 1);
            check("ld addr_sel", mem_addr_sel, 1);
            check("ld mem_we", mem_we, 0);
            check("ld reg_we", reg_we, 0);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("ldwb reg_we", reg_we, 1);
        check("ldwb result_sel", result_sel, 2);
        check("ldwb retire", retire, 1);
        check("ldwb mem_req", mem_req, 0);
        tick(); exp_cnt++;

        // BCOND cond 0 (b4) taken, then not taken, then cond A (!b4 & !b0)
        psr = 5'b10000;
        start_instr(4'hC, 4'h0, 4'h0, 1'b0);
        check("bc0 taken pc_en", pc_en, 1);
        check("bc0 taken pc_src", pc_src, 1);
        check("bc0 taken retire", retire, 1);
        tick(); exp_cnt++;
        psr = 5'b00000;
        start_instr(4'hC, 4'h0, 4'h0, 1'b0);
        check("bc0 ntaken pc_en", pc_en, 0);
        check("bc0 ntaken retire", retire, 1);
        tick(); exp_cnt++;
        psr = 5'b00010;
        start_instr(4'hC, 4'h0, 4'hA, 1'b0);
        check("bcA pc_en", pc_en, 1);
        tick(); exp_cnt++;
        psr = 5'b00001;
        start_instr(4'hC, 4'h0, 4'hA, 1'b0);
        check("bcA b0 pc_en", pc_en, 0);
        tick(); exp_cnt++;

        // CMPI: flags only
        start_instr(4'hB, 4'h0, 4'h0, 1'b0);
        check("cmpi psr_en", psr_en, 1);
        check("cmpi alu", alu_ctrl, 4'hB);
        tick();
        check("cmpi reg_we", reg_we, 0);
        check("cmpi retire", retire, 1);
        tick(); exp_cnt++;

        // CMP (R-type, opcode2 B)
        start_instr(4'h0, 4'hB, 4'h0, 1'b0);
        check("cmp alu", alu_ctrl, 4'hB);
        check("cmp src_b_imm", src_b_imm, 0);
        tick();
        check("cmp reg_we", reg_we, 0);
        tick(); exp_cnt++;

        // Register-amount shift, then immediate shift
        start_instr(4'h8, 4'h4, 4'h0, 1'b0);
        check("shr shift_ctrl", shift_ctrl, 4'h4);
        check("shr src_b_imm", src_b_imm, 0);
        check("shr result_sel", result_sel, 0);
        check("shr result_en", result_en, 1);
        tick();
        check("shr reg_we", reg_we, 1);
        tick(); exp_cnt++;
        start_instr(4'hF, 4'h4, 4'h0, 1'b0);
        check("shi shift_ctrl", shift_ctrl, 4'hF);
        check("shi src_b_imm", src_b_imm, 1);
        tick();
        tick(); exp_cnt++;

        // Store
        start_instr(4'h4, 4'h4, 4'h0, 1'b0);
        tick();
        check("st mem_req", mem_req, 1);
        check("st mem_we", mem_we, 1);
        check("st addr_sel", mem_addr_sel, 1);
        check("st retire", retire, 1);
        tick(); exp_cnt++;

        // JAL
        start_instr(4'h4, 4'h8, 4'h0, 1'b0);
        tick();
        check("jal result_sel", result_sel, 3);
        check("jal pc_src", pc_src, 2);
        check("jal pc_en", pc_en, 1);
        check("jal retire", retire, 0);
        tick();
        check("jalwb reg_we", reg_we, 1);
        check("jalwb retire", retire, 1);
        tick(); exp_cnt++;

        // Undefined primary opcode
        start_instr(4'h6, 4'h0, 4'h0, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
        check("trap illegal", illegal, 1);
        check("trap pc_src", pc_src, 3);
        check("trap pc_en", pc_en, 1);
        check("trap retire", retire, 0);
        tick();
`endif
        check("illegal after mem_req", mem_req, 1);
        check("illegal after pulse", illegal, 0);
`ifndef ILLEGAL_OP_TRAP_EN
        exp_cnt++;
`endif
        check("illegal cnt", retired_cnt, exp_cnt);

        // Reset while fetch is waiting on memory
        mem_ready = 1'b0;
        #1;
        check("fwait ir_en", ir_en, 0);
        tick();
        check("fwait mem_req", mem_req, 1);
        reset = 1'b1;
        tick();
        check("rstwait mem_req", mem_req, 0);
        check("rstwait cnt", retired_cnt, 0);
        reset = 1'b0;
        exp_cnt = 0;
        start_instr(4'h5, 4'h0, 4'h0, 1'b0);
        tick();
        tick(); exp_cnt++;
        check("post-rst cnt", retired_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
